sobel_hls_udiv_29_22: RTL and testbench
=======================================

SOBEL_HLS_UDIV_29_22 -- requirements
Module: sobel_hls_udiv_29_22

Interface
REQ-001 The block SHALL have parameter ID, default 32'd1, used as an instance tag with no functional effect.
REQ-002 The block SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port ap_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand pair on din0/din1 is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-006 The block SHALL have port din0, input, 29 bits: unsigned dividend.
REQ-007 The block SHALL have port din1, input, 22 bits: unsigned divisor.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result on dout_q/dout_r/ovf is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port dout_q, output, 8 bits: unsigned quotient.
REQ-011 The block SHALL have port dout_r, output, 22 bits: unsigned remainder.
REQ-012 The block SHALL have port ovf, output, 1 bit: quotient saturated, either divisor zero or true quotient greater than 255.

Function
REQ-013 The block SHALL compute floor(din0/din1) and din0 mod din1 when din1 != 0 and din0 < din1*256; this is the inverse of the 8x22 unsigned multiply.
REQ-014 The block SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-015 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-016 An operand transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; din0/din1 are captured into internal registers on that edge.
REQ-017 Overflow detection SHALL be performed on the transfer edge.
  - Condition: din1==0, or din0[28:8] >= din1 (compare zero-extended to 22 bits).
  - On overflow: go to DONE with dout_q=8'd255, dout_r=0, ovf=1.
REQ-018 If no overflow is detected, the FSM SHALL go from IDLE to CALC with:
  - partial remainder R = din0[28:8] (21 bits, zero-extended to 22 bits);
  - step counter = 7.
REQ-019 Each CALC cycle SHALL perform one restoring step, MSB first:
  - T = {R, dividend bit[counter]}, 23 bits;
  - if T >= divisor: R = T - divisor and quotient bit[counter] = 1; else R = T[21:0] and bit = 0.
REQ-020 After the step with counter==0, the FSM SHALL go to DONE with dout_q = quotient, dout_r = R, ovf=0.
REQ-021 Latency from the transfer edge to out_valid high SHALL be 9 cycles normally and 1 cycle on overflow.
REQ-022 In DONE, dout_q/dout_r/ovf SHALL be held stable until a rising edge with out_ready=1; the FSM then returns to IDLE.
REQ-023 in_valid SHALL be ignored outside IDLE.
REQ-024 A new transfer SHALL NOT occur on the same edge as result consumption; throughput is at most one operation per 10 cycles (normal) or 2 cycles (overflow).
REQ-025 Between operations, dout_q/dout_r/ovf SHALL retain the last result while in IDLE.
REQ-026 Values on these outputs are undefined for the consumer while out_valid=0.
REQ-027 Arithmetic SHALL be unsigned, with no internal width loss: the compare/subtract uses 23 bits and the remainder is always < divisor.

Reset
REQ-028 When ap_rst=1 on a rising edge, the FSM SHALL go to IDLE and dout_q=0, dout_r=0, ovf=0, out_valid=0, with in_ready=1 on the following cycle.
REQ-029 Reset SHALL take priority over all handshakes and SHALL abort any CALC or DONE operation, discarding its result.
REQ-030 The first transfer SHALL be accepted on the first edge with ap_rst=0 and in_valid=1.

Verification
REQ-031 The bench SHALL apply din0=1000, din1=7 -> dout_q=142, dout_r=6, ovf=0, out_valid high exactly 9 cycles after the transfer.
REQ-032 The bench SHALL apply din0=511999999, din1=2000000 -> dout_q=255, dout_r=1999999, ovf=0.
REQ-033 The bench SHALL test both sides of the overflow boundary:
  - din0=1280, din1=5 -> dout_q=255, dout_r=0, ovf=1, out_valid 1 cycle after transfer;
  - din0=1279, din1=5 -> dout_q=255, dout_r=4, ovf=0.
REQ-034 The bench SHALL apply din1=0 with any din0 -> dout_q=255, dout_r=0, ovf=1 after 1 cycle.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles in DONE and check outputs stable, in_ready=0 and in_valid ignored; then, with out_ready=1 for one edge, out_valid=0 and in_ready=1 on the next cycle.
REQ-036 The bench SHALL assert ap_rst for one cycle in the 4th CALC cycle and check out_valid=0, in_ready=1, all outputs 0; a subsequent din0=1000, din1=7 SHALL return 142/6.

Source files
------------

// File: rtl/sobel_hls_udiv_29_22.sv
// Sequential 29/22-bit unsigned divider with an 8-bit quotient.
// It is the inverse of an 8x22 unsigned multiply and uses one restoring step per cycle.
// If the divisor is zero, or the true quotient does not fit in 8 bits, the result
// saturates at 255 with ovf set.
module sobel_hls_udiv_29_22 #(
  parameter logic [31:0] ID = 32'd1
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [28:0] din0,
  input  logic [21:0] din1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  dout_q,
  output logic [21:0] dout_r,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic [7:0]  dividend_lo;
  logic [21:0] divisor;
  logic [21:0] rem;
  logic [7:0]  quot;
  logic [2:0]  cnt;

  logic        transfer;
  logic        ovf_det;
  logic [22:0] trial;
  logic        step_bit;
  logic [21:0] rem_step;
  logic [7:0]  quot_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign transfer  = in_valid && in_ready;

  // The upper 21 dividend bits form the first partial remainder.
  // If they already reach the divisor, the quotient cannot fit in 8 bits.
  assign ovf_det = (din1 == 22'd0) || ({1'b0, din0[28:8]} >= din1);

  // One restoring step: shift in the next dividend bit, then subtract when the divisor fits.
  // The partial remainder is always below the divisor, so the difference fits in 22 bits.
  always_comb begin
    trial     = {rem, dividend_lo[cnt]};
    step_bit  = (trial >= {1'b0, divisor});
    rem_step  = step_bit ? (trial[21:0] - divisor) : trial[21:0];
    quot_step = quot;
    quot_step[cnt] = step_bit;
  end

  // State register; reset aborts any operation that is in flight.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: accept operands in IDLE, iterate in CALC, and hold in DONE until the result is taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (transfer) state_next = ovf_det ? DONE : CALC;
      CALC: if (cnt == 3'd0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands, run the restoring steps, and publish the result.
  // The result stays on the outputs until a new result replaces it.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dividend_lo <= 8'd0;
      divisor     <= 22'd0;
      rem         <= 22'd0;
      quot        <= 8'd0;
      cnt         <= 3'd0;
      dout_q      <= 8'd0;
      dout_r      <= 22'd0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            dividend_lo <= din0[7:0];
            divisor     <= din1;
            rem         <= {1'b0, din0[28:8]};
            quot        <= 8'd0;
            cnt         <= 3'd7;
            if (ovf_det) begin
              dout_q <= 8'd255;
              dout_r <= 22'd0;
              ovf    <= 1'b1;
            end
          end
        end
        CALC: begin
          rem  <= rem_step;
          quot <= quot_step;
          cnt  <= cnt - 3'd1;
          if (cnt == 3'd0) begin
            dout_q <= quot_step;
            dout_r <= rem_step;
            ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_hls_udiv_29_22.sv
// Testbench for sobel_hls_udiv_29_22.
// It drives directed divide vectors and checks every valid result against a plain arithmetic model.
module tb_sobel_hls_udiv_29_22;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [28:0] din0 = '0;
  logic [21:0] din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  dout_q;
  logic [21:0] dout_r;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  logic        exp_pending = 1'b0;
  logic [7:0]  exp_q = '0;
  logic [21:0] exp_r = '0;
  logic        exp_o = 1'b0;

  sobel_hls_udiv_29_22 #(.ID(32'd1)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout_q(dout_q), .dout_r(dout_r), .ovf(ovf)
  );

  // Free-running clock.
  always #5 ap_clk = ~ap_clk;

  // Reference behaviour: a true quotient above 255, or a zero divisor, saturates.
  function automatic void model_div(input logic [28:0] a, input logic [21:0] b,
                                    output logic [7:0] q, output logic [21:0] r, output logic o);
    longint unsigned qa;
    if (b == 22'd0) begin
      q = 8'd255; r = 22'd0; o = 1'b1;
    end else begin
      qa = longint'(a) / longint'(b);
      if (qa > 255) begin
        q = 8'd255; r = 22'd0; o = 1'b1;
      end else begin
        q = 8'(qa);
        r = 22'(longint'(a) % longint'(b));
        o = 1'b0;
      end
    end
  endfunction

  task automatic check_output(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // On every cycle with a valid result, compare the outputs with the model's expectation.
  always @(negedge ap_clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (!exp_pending || dout_q !== exp_q || dout_r !== exp_r || ovf !== exp_o || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL result: got q=%0d r=%0d ovf=%0d in_ready=%0d, expected q=%0d r=%0d ovf=%0d in_ready=0 (pending=%0d)",
                 dout_q, dout_r, ovf, in_ready, exp_q, exp_r, exp_o, exp_pending);
      end
    end
  end

  // One operation: transfer the operands, wait for the result, optionally stall, then consume.
  // lit_* are hand-computed values that pin the model when use_lit is set.
  task automatic apply_stimulus(input logic [28:0] a, input logic [21:0] b, input int hold,
                                input bit use_lit, input logic [7:0] lit_q,
                                input logic [21:0] lit_r, input logic lit_o);
    logic [7:0]  mq;
    logic [21:0] mr;
    logic        mo;
    int          cycles;
    model_div(a, b, mq, mr, mo);
    if (use_lit) begin
      check_output("model_q", mq, lit_q);
      check_output("model_r", mr, lit_r);
      check_output("model_ovf", mo, lit_o);
    end
    check_output("in_ready_idle", in_ready, 1);
    exp_q = mq; exp_r = mr; exp_o = mo; exp_pending = 1'b1;
    din0 = a; din1 = b; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    din0 = 29'($urandom); din1 = 22'($urandom);
    cycles = 1;
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(posedge ap_clk); #1;
      cycles++;
    end
    check_output("latency", cycles, mo ? 1 : 9);
    if (use_lit) begin
      check_output("dout_q", dout_q, lit_q);
      check_output("dout_r", dout_r, lit_r);
      check_output("ovf", ovf, lit_o);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      din0 = 29'($urandom); din1 = 22'($urandom);
      @(posedge ap_clk); #1;
      check_output("stall_in_ready", in_ready, 0);
      check_output("stall_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    exp_pending = 1'b0;
    check_output("consume_out_valid", out_valid, 0);
    check_output("consume_in_ready", in_ready, 1);
    check_output("retain_q", dout_q, mq);
    check_output("retain_r", dout_r, mr);
    check_output("retain_ovf", ovf, mo);
  endtask

  // Main sequence: reset, directed vectors, stall, mid-calculation reset, and a few model-only vectors.
  initial begin
    logic [21:0] rb;
    logic [28:0] ra;
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_q", dout_q, 0);
    check_output("rst_r", dout_r, 0);
    check_output("rst_ovf", ovf, 0);

    apply_stimulus(29'd1000, 22'd7, 0, 1'b1, 8'd142, 22'd6, 1'b0);
    apply_stimulus(29'd511999999, 22'd2000000, 0, 1'b1, 8'd255, 22'd1999999, 1'b0);
    apply_stimulus(29'd1280, 22'd5, 0, 1'b1, 8'd255, 22'd0, 1'b1);
    apply_stimulus(29'd1279, 22'd5, 0, 1'b1, 8'd255, 22'd4, 1'b0);
    apply_stimulus(29'd12345, 22'd0, 0, 1'b1, 8'd255, 22'd0, 1'b1);
    apply_stimulus(29'd0, 22'd1, 0, 1'b1, 8'd0, 22'd0, 1'b0);
    apply_stimulus(29'd256, 22'd1, 0, 1'b1, 8'd255, 22'd0, 1'b1);
    apply_stimulus(29'd536870911, 22'd4194303, 0, 1'b1, 8'd128, 22'd127, 1'b0);
    apply_stimulus(29'd1000, 22'd7, 5, 1'b1, 8'd142, 22'd6, 1'b0);
    apply_stimulus(29'd99, 22'd0, 5, 1'b1, 8'd255, 22'd0, 1'b1);

    // Reset during the 4th CALC cycle discards the operation.
    din0 = 29'd1000; din1 = 22'd7; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge ap_clk); #1; end
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    check_output("abort_out_valid", out_valid, 0);
    check_output("abort_in_ready", in_ready, 1);
    check_output("abort_q", dout_q, 0);
    check_output("abort_r", dout_r, 0);
    check_output("abort_ovf", ovf, 0);
    apply_stimulus(29'd1000, 22'd7, 0, 1'b1, 8'd142, 22'd6, 1'b0);

    for (int k = 0; k < 6; k++) begin
      rb = 22'($urandom_range(1, 4194303));
      ra = 29'($urandom_range(0, 536870911));
      if (k[0]) ra = 29'(longint'(ra) % (longint'(rb) * 256));
      apply_stimulus(ra, rb, k % 3, 1'b0, 8'd0, 22'd0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
